// File: rtl/eth_rx_frame_buffer_if.sv
// CPU memory-bus view of the Ethernet receive frame buffer.
// The CPU drives the address and strobes; the buffer answers with read data.
interface eth_rx_frame_buffer_if;
    logic [15:0] a;
    logic        n_oe;
    logic        n_we;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        n_rdy;

    modport master (
        output a, n_oe, n_we, d_in,
        input  d_out, d_oe, n_rdy
    );

    modport slave (
        input  a, n_oe, n_we, d_in,
        output d_out, d_oe, n_rdy
    );
endinterface

// File: rtl/eth_rx_frame_buffer.sv
// Receive frame buffer: byte RAM filled by the bit-level receiver, a frame-received
// flag captured from the MAC filter verdict, and a combinational CPU read decoder.
module eth_rx_frame_buffer #(
    parameter int unsigned A_WIDTH       = 11,
    parameter logic [7:0]  INITIAL_VALUE = 8'h26
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               n_recv_ss,
    input  logic               n_inhibit,
    input  logic [7:0]         recv_byte,
    input  logic [A_WIDTH-1:0] recv_byte_cnt,
    input  logic               n_recv_buf_we,
    output logic               recv_ena,
    eth_rx_frame_buffer_if.slave bus
);
    localparam int unsigned DEPTH = 1 << A_WIDTH;

    logic [7:0]  ram [0:DEPTH-1] = '{default: INITIAL_VALUE};
    logic        buf_full;
    logic        ss_q;
    logic        recv_sel;
    logic        ss_rise;
    logic        cpu_clear;
    logic [15:0] cnt_ext;

    assign recv_ena  = ~buf_full;
    assign recv_sel  = recv_ena & ~n_recv_ss;
    assign ss_rise   = n_recv_ss & ~ss_q;
    assign cpu_clear = ~bus.n_we & (bus.a == 16'hFB00);
    assign cnt_ext   = 16'(recv_byte_cnt);
    assign bus.n_rdy = 1'b0;

    // RAM is never cleared by reset; writes are simply held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (n_rst && recv_sel && !n_recv_buf_we) begin
            ram[recv_byte_cnt] <= recv_byte;
        end
    end

    // End-of-frame capture takes precedence over a simultaneous CPU clear.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            buf_full <= 1'b0;
            ss_q     <= 1'b1;
        end else begin
            ss_q <= n_recv_ss;
            if (ss_rise) begin
                buf_full <= n_inhibit;
            end else if (cpu_clear) begin
                buf_full <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.d_out = '0;
        bus.d_oe  = 1'b0;
        if (!bus.n_oe) begin
            if (bus.a[15:11] == 5'b11110) begin
                bus.d_oe  = 1'b1;
                bus.d_out = recv_sel ? recv_byte : ram[bus.a[A_WIDTH-1:0]];
            end else if (bus.a == 16'hFB00) begin
                bus.d_oe  = 1'b1;
                bus.d_out = {7'b0, buf_full};
            end else if (bus.a == 16'hFB02) begin
                bus.d_oe  = 1'b1;
                bus.d_out = cnt_ext[7:0];
            end else if (bus.a == 16'hFB03) begin
                bus.d_oe  = 1'b1;
                bus.d_out = cnt_ext[15:8];
            end
        end
    end
endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Randomized bench for eth_rx_frame_buffer against a frame-level reference model.
module tb_eth_rx_frame_buffer;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        n_recv_ss;
    logic        n_inhibit;
    logic [7:0]  recv_byte;
    logic [10:0] recv_byte_cnt;
    logic        n_recv_buf_we;
    logic        recv_ena;

    eth_rx_frame_buffer_if bus ();

    eth_rx_frame_buffer #(.A_WIDTH(11), .INITIAL_VALUE(8'h26)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .n_recv_ss     (n_recv_ss),
        .n_inhibit     (n_inhibit),
        .recv_byte     (recv_byte),
        .recv_byte_cnt (recv_byte_cnt),
        .n_recv_buf_we (n_recv_buf_we),
        .recv_ena      (recv_ena),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: RAM image and frame flag, updated per frame / per CPU clear.
    logic [7:0] m_ram [0:2047];
    logic       m_full;

    int unsigned n_errors = 0;
    int unsigned n_checks = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_read(input logic [15:0] addr, output logic oe, output logic [7:0] data);
        logic [10:0] idx;
        idx  = addr[10:0];
        oe   = 1'b1;
        data = 8'h00;
        if (addr >= 16'hF000 && addr <= 16'hF7FF) data = m_ram[idx];
        else if (addr == 16'hFB00)                data = {7'b0, m_full};
        else if (addr == 16'hFB02)                data = recv_byte_cnt[7:0];
        else if (addr == 16'hFB03)                data = {5'b0, recv_byte_cnt[10:8]};
        else                                      oe   = 1'b0;
    endfunction

    // Idle-time CPU read compared against the model.
    task automatic cpu_read(input string tag, input logic [15:0] addr);
        logic       e_oe;
        logic [7:0] e_d;
        bus.a    = addr;
        bus.n_oe = 1'b0;
        #1;
        model_read(addr, e_oe, e_d);
        check({tag, "_oe"}, 16'(bus.d_oe), 16'(e_oe));
        check({tag, "_d"}, 16'(bus.d_out), 16'(e_d));
        bus.n_oe = 1'b1;
    endtask

    task automatic cpu_clear();
        @(negedge clk);
        bus.a    = 16'hFB00;
        bus.n_we = 1'b0;
        @(negedge clk);
        bus.n_we = 1'b1;
        m_full   = 1'b0;
    endtask

    // One frame: window low, nbytes written from start, window raised with the verdict.
    task automatic run_frame(input int unsigned nbytes, input logic [10:0] start, input logic accept,
                             input bit clear_at_end, input bit use_fixed, input logic [7:0] fixed_byte);
        logic [10:0] cnt;
        logic [7:0]  b;
        @(negedge clk);
        n_recv_ss     = 1'b0;
        n_recv_buf_we = 1'b1;
        for (int unsigned i = 0; i < nbytes; i++) begin
            @(negedge clk);
            cnt           = start + 11'(i);
            b             = use_fixed ? fixed_byte : 8'($urandom);
            recv_byte     = b;
            recv_byte_cnt = cnt;
            n_recv_buf_we = 1'b0;
            bus.a         = {5'b11110, cnt};
            bus.n_oe      = 1'b0;
            #1;
            check("frame_ena", 16'(recv_ena), 16'(!m_full));
            check("frame_rd", 16'(bus.d_out), 16'(m_full ? m_ram[cnt] : b));
            bus.n_oe = 1'b1;
            if (!m_full) m_ram[cnt] = b;
        end
        @(negedge clk);
        n_recv_buf_we = 1'b1;
        n_recv_ss     = 1'b1;
        n_inhibit     = accept;
        if (clear_at_end) begin
            bus.a    = 16'hFB00;
            bus.n_we = 1'b0;
        end
        @(negedge clk);
        bus.n_we  = 1'b1;
        n_inhibit = 1'($urandom);
        m_full    = accept;
        check("end_ena", 16'(recv_ena), 16'(!accept));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) m_ram[i] = 8'h26;
        m_full        = 1'b0;
        n_rst         = 1'b0;
        n_recv_ss     = 1'b1;
        n_inhibit     = 1'b1;
        recv_byte     = 8'h00;
        recv_byte_cnt = 11'h000;
        n_recv_buf_we = 1'b1;
        bus.a         = 16'h0000;
        bus.n_oe      = 1'b1;
        bus.n_we      = 1'b1;
        bus.d_in      = 8'h00;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        check("rst_ena", 16'(recv_ena), 16'h1);
        check("rst_rdy", 16'(bus.n_rdy), 16'h0);
        cpu_read("rst_fb00", 16'hFB00);
        cpu_read("rst_f123", 16'hF123);
        bus.a = 16'hFB00;
        #1;
        check("noe_oe", 16'(bus.d_oe), 16'h0);
        check("noe_d", 16'(bus.d_out), 16'h0);

        run_frame(1, 11'd5, 1'b1, 1'b0, 1'b1, 8'hAB);
        check("acc_ena", 16'(recv_ena), 16'h0);
        cpu_read("acc_fb00", 16'hFB00);
        cpu_read("acc_f005", 16'hF005);

        run_frame(1, 11'd5, 1'b1, 1'b0, 1'b1, 8'h55);
        cpu_read("full_f005", 16'hF005);

        cpu_clear();
        cpu_read("clr_fb00", 16'hFB00);
        check("clr_ena", 16'(recv_ena), 16'h1);

        run_frame(3, 11'd100, 1'b0, 1'b0, 1'b0, 8'h00);
        cpu_read("rej_fb00", 16'hFB00);
        check("rej_ena", 16'(recv_ena), 16'h1);
        cpu_read("rej_f064", 16'hF064);

        recv_byte_cnt = 11'h3A7;
        cpu_read("cnt_fb02", 16'hFB02);
        cpu_read("cnt_fb03", 16'hFB03);
        cpu_read("fb01", 16'hFB01);
        cpu_read("x1000", 16'h1000);

        run_frame(2, 11'h7FF, 1'b1, 1'b1, 1'b0, 8'h00);
        cpu_read("coin_fb00", 16'hFB00);
        cpu_read("wrap_f7ff", 16'hF7FF);
        cpu_read("wrap_f000", 16'hF000);

        // Reset clears the flag but leaves the RAM alone.
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst  = 1'b1;
        m_full = 1'b0;
        cpu_read("rst2_fb00", 16'hFB00);
        cpu_read("rst2_f000", 16'hF000);

        for (int unsigned it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0, 1: run_frame($urandom_range(1, 6),
                                ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2043, 2047)) : 11'($urandom),
                                1'($urandom), 1'($urandom), 1'b0, 8'h00);
                2: cpu_clear();
                default: begin
                    @(negedge clk);
                    recv_byte_cnt = 11'($urandom);
                end
            endcase
            for (int unsigned r = 0; r < 3; r++) begin
                case ($urandom_range(0, 3))
                    0:       cpu_read("rnd_ram", 16'hF000 | 16'($urandom_range(0, 2047)));
                    1:       cpu_read("rnd_reg", 16'hFB00 | 16'($urandom_range(0, 3)));
                    2:       cpu_read("rnd_any", 16'($urandom));
                    default: cpu_read("rnd_ram", 16'hF7F8 | 16'($urandom_range(0, 7)));
                endcase
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
